guess_game_core: RTL
====================

# guess_game_core

Parametrised number-guessing game engine between the keypad/entry path and the text-LCD driver. It draws an in-range target from a free-running random source and scores up to MAX_TRIALS guesses against it. On each guess it emits one command code, tracks the narrowing legal range, and counts games won. It generalises the fixed 5-trial controller with configurable width, range and trial count, bound tracking with out-of-range rejection, a win counter, and an optional per-guess timeout.

## Interface
- WIDTH, 8, bit width of guess, target and bounds (unsigned binary)
- MAX_VALUE, 99, largest legal target/guess; must be < 2^WIDTH
- MAX_TRIALS, 5, guesses per game, 1..2^TRIAL_W-1
- TRIAL_W, 3, width of trials_left
- TIMEOUT_CYCLES, 1000, per-guess timeout; used only with GUESS_TIMEOUT_EN
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- guess_valid  in  1  one-cycle strobe, guess entered (* key)
- guess  in  WIDTH  guess value, sampled when guess_valid=1
- rand_in  in  WIDTH  free-running pseudo-random value
- cmd  out  3  LCD command: 000 correct, 001 failed, 010 up, 011 down, 100 retry?, 101 start, 110 enter number, 111 out of range
- cmd_valid  out  1  one-cycle pulse when cmd is written
- trials_left  out  TRIAL_W  remaining guesses
- low_bound, high_bound  out  WIDTH each  current legal range, inclusive
- wins  out  8  games won, saturating at 255
- state_o  out  2  IDLE=00, ARM=01, PLAY=10, END=11

## Operation
- IDLE: entered on rst. Unconditionally moves to ARM the next cycle.
- ARM: samples rand_in every cycle (rejection sampling). If rand_in > MAX_VALUE, stay in ARM.
- ARM capture: when rand_in <= MAX_VALUE, set target=rand_in, trials_left=MAX_TRIALS, low=0, high=MAX_VALUE, cmd=110 with pulse, then go to PLAY. guess_valid is ignored in IDLE/ARM.
- PLAY, on guess_valid, evaluated in priority order:
  - guess<low or guess>high: cmd=111; no trial consumed; bounds unchanged.
  - guess==target: cmd=000; wins+=1 (saturating); go to END; trials_left unchanged.
  - otherwise trials_left-=1. If the new value is 0: cmd=001, go to END.
  - else if guess>target: cmd=011, high=guess-1.
  - else: cmd=010, low=guess+1.
- Bound arithmetic never wraps: a wrong guess always lies strictly inside [low, high] around target, so guess-1 >= low and guess+1 <= high.
- END, on guess_valid:
  - guess==1: cmd=101, go to ARM.
  - guess==0: cmd=100 re-issued; stay in END.
  - any other value: ignored, no pulse.
- Exactly one cmd write, and one cmd_valid pulse, per accepted event. No other cycle pulses.

## Timing
- All outputs are registered. Response appears on the clock edge after the guess_valid sample: 1-cycle latency.
- Back-to-back guess_valid on consecutive cycles are each processed, one cmd pulse per cycle.
- Reset values: state_o=00, cmd=110, cmd_valid=0, trials_left=MAX_TRIALS, low=0, high=MAX_VALUE, wins=0, target=0, timeout counter=0.
- rst asserted mid-game overrides every event that cycle; wins is cleared.
- From reset to first PLAY cycle: 2 cycles plus one cycle per rejected rand_in sample.

## Configuration
- GUESS_TIMEOUT_EN defined:
  - In PLAY a counter increments each cycle and clears on guess_valid and on entry to PLAY.
  - When it reaches TIMEOUT_CYCLES-1 without a guess, a trial is consumed. If trials_left becomes 0: cmd=001, go to END. Otherwise cmd=110 (re-prompt) and the counter clears.
  - guess_valid in the same cycle as expiry takes priority: the guess is processed and the counter clears.
- GUESS_TIMEOUT_EN undefined: no counter logic; PLAY waits indefinitely; TIMEOUT_CYCLES unused.

## Test plan
All scenarios use the default parameters.
- Reset; rand_in=150 for 3 ARM cycles, then 42 -> ARM held 3 cycles; then cmd=110 pulse, trials_left=5, low=0, high=99, state PLAY.
- Target 42, guesses 50, 30, 42 -> 011 (high=49, trials 4); 010 (low=31, trials 3); 000 with wins=1, END, trials 3.
- After high=49, guess 60; then guess 20 with low=31 -> 111 each time; trials_left and bounds unchanged.
- Target 42, guesses 10, 11, 12, 13, 14 -> four 010 pulses; then 001 and END with trials_left=0. In END: guess 7 -> no pulse; guess 0 -> 100; guess 1 -> 101 and ARM.
- rst asserted in PLAY with wins=3 and the same cycle as guess_valid -> no cmd_valid; all outputs at reset values next cycle.
- GUESS_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - idle in PLAY -> cmd=110 and trials 5->4 after 8 cycles.
  - guess at expiry cycle -> guess result only; counter cleared.

Source files
------------

// File: rtl/guess_game_core.sv
// Number-guessing game engine: draws a target from rand_in, scores guesses and emits LCD command codes.
// Define GUESS_TIMEOUT_EN to add a per-guess timeout that consumes a trial after TIMEOUT_CYCLES idle cycles.
module guess_game_core #(
    parameter int WIDTH          = 8,
    parameter int MAX_VALUE      = 99,
    parameter int MAX_TRIALS     = 5,
    parameter int TRIAL_W        = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               guess_valid,
    input  logic [WIDTH-1:0]   guess,
    input  logic [WIDTH-1:0]   rand_in,
    output logic [2:0]         cmd,
    output logic               cmd_valid,
    output logic [TRIAL_W-1:0] trials_left,
    output logic [WIDTH-1:0]   low_bound,
    output logic [WIDTH-1:0]   high_bound,
    output logic [7:0]         wins,
    output logic [1:0]         state_o
);

    // Reject parameter sets the datapath widths cannot represent.
    if (MAX_VALUE >= (1 << WIDTH) || MAX_VALUE < 0 || MAX_TRIALS < 1 ||
        MAX_TRIALS >= (1 << TRIAL_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("guess_game_core: illegal parameter combination");
    end

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;
    localparam logic [1:0] S_END  = 2'b11;

    localparam logic [2:0] CMD_CORRECT = 3'b000;
    localparam logic [2:0] CMD_FAILED  = 3'b001;
    localparam logic [2:0] CMD_UP      = 3'b010;
    localparam logic [2:0] CMD_DOWN    = 3'b011;
    localparam logic [2:0] CMD_RETRY   = 3'b100;
    localparam logic [2:0] CMD_START   = 3'b101;
    localparam logic [2:0] CMD_ENTER   = 3'b110;
    localparam logic [2:0] CMD_RANGE   = 3'b111;

    localparam logic [WIDTH-1:0]   MAX_V       = WIDTH'(MAX_VALUE);
    localparam logic [TRIAL_W-1:0] TRIALS_INIT = TRIAL_W'(MAX_TRIALS);

    logic [1:0]         state, state_n;
    logic [WIDTH-1:0]   target, target_n;
    logic [WIDTH-1:0]   low_n, high_n;
    logic [TRIAL_W-1:0] trials_n, trials_dec;
    logic [7:0]         wins_n;
    logic [2:0]         cmd_n;
    logic               cmd_valid_n;
    logic               in_range;
    logic               timeout_hit;

    assign trials_dec = trials_left - TRIAL_W'(1);
    assign in_range   = (guess >= low_bound) && (guess <= high_bound);
    assign state_o    = state;

`ifdef GUESS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_count;

    assign timeout_hit = (state == S_PLAY) && (to_count == TO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside PLAY, so every entry to PLAY starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_count <= '0;
        end else if (state != S_PLAY || guess_valid || timeout_hit) begin
            to_count <= '0;
        end else begin
            to_count <= to_count + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        target_n    = target;
        trials_n    = trials_left;
        low_n       = low_bound;
        high_n      = high_bound;
        wins_n      = wins;
        cmd_n       = cmd;
        cmd_valid_n = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_ARM;
            end

            // Rejection sampling keeps the target uniform over 0..MAX_VALUE.
            S_ARM: begin
                if (rand_in <= MAX_V) begin
                    target_n    = rand_in;
                    trials_n    = TRIALS_INIT;
                    low_n       = '0;
                    high_n      = MAX_V;
                    cmd_n       = CMD_ENTER;
                    cmd_valid_n = 1'b1;
                    state_n     = S_PLAY;
                end
            end

            S_PLAY: begin
                if (guess_valid) begin
                    cmd_valid_n = 1'b1;
                    if (!in_range) begin
                        cmd_n = CMD_RANGE;
                    end else if (guess == target) begin
                        cmd_n   = CMD_CORRECT;
                        state_n = S_END;
                        if (wins != 8'hFF) begin
                            wins_n = wins + 8'd1;
                        end
                    end else begin
                        trials_n = trials_dec;
                        if (trials_dec == '0) begin
                            cmd_n   = CMD_FAILED;
                            state_n = S_END;
                        end else if (guess > target) begin
                            cmd_n  = CMD_DOWN;
                            high_n = guess - WIDTH'(1);
                        end else begin
                            cmd_n = CMD_UP;
                            low_n = guess + WIDTH'(1);
                        end
                    end
                end else if (timeout_hit) begin
                    cmd_valid_n = 1'b1;
                    trials_n    = trials_dec;
                    if (trials_dec == '0) begin
                        cmd_n   = CMD_FAILED;
                        state_n = S_END;
                    end else begin
                        cmd_n = CMD_ENTER;
                    end
                end
            end

            S_END: begin
                if (guess_valid) begin
                    if (guess == WIDTH'(1)) begin
                        cmd_n       = CMD_START;
                        cmd_valid_n = 1'b1;
                        state_n     = S_ARM;
                    end else if (guess == '0) begin
                        cmd_n       = CMD_RETRY;
                        cmd_valid_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            target      <= '0;
            trials_left <= TRIALS_INIT;
            low_bound   <= '0;
            high_bound  <= MAX_V;
            wins        <= 8'd0;
            cmd         <= CMD_ENTER;
            cmd_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            target      <= target_n;
            trials_left <= trials_n;
            low_bound   <= low_n;
            high_bound  <= high_n;
            wins        <= wins_n;
            cmd         <= cmd_n;
            cmd_valid   <= cmd_valid_n;
        end
    end

endmodule
